// File: rtl/data_sync_rsp.sv
// Destination-side responder of a 4-phase req/ack crossing: synchronizes req, captures the
// source-held word, hands it to a valid/ready consumer and returns a registered ack level.
// Optional source-parity check is built when DATA_SYNC_RSP_PARITY_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for synchronized req high; capture word on it
// WAIT_RDY | word presented on dest_data/dest_valid until consumer takes it
// WAIT_REL | ack held high until synchronized req falls
module data_sync_rsp #(
   parameter int BUS_WIDTH   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 dest_clk,
   input  logic                 dest_rst,
   input  logic                 src_req,
   input  logic [BUS_WIDTH-1:0] src_data,
   input  logic                 dest_ready,
`ifdef DATA_SYNC_RSP_PARITY_EN
   input  logic                 src_parity,
   input  logic                 err_clr,
   output logic                 parity_err,
`endif
   output logic [BUS_WIDTH-1:0] dest_data,
   output logic                 dest_valid,
   output logic                 src_ack,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_sync;
   logic [BUS_WIDTH-1:0]   data_nxt;
   logic                   valid_nxt;
   logic                   ack_nxt;

   // src_req is touched only by the first flop of this chain
   always_ff @(posedge dest_clk or negedge dest_rst) begin
      if (!dest_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
      end
   end

   assign req_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge dest_clk or negedge dest_rst) begin
      if (!dest_rst) begin
         state      <= IDLE;
         dest_data  <= '0;
         dest_valid <= 1'b0;
         src_ack    <= 1'b0;
      end else begin
         state      <= state_nxt;
         dest_data  <= data_nxt;
         dest_valid <= valid_nxt;
         src_ack    <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = dest_data;
      valid_nxt = dest_valid;
      ack_nxt   = src_ack;
      case (state)
         IDLE: begin
            if (req_sync) begin
               data_nxt  = src_data;
               valid_nxt = 1'b1;
               state_nxt = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (dest_valid && dest_ready) begin
               valid_nxt = 1'b0;
               ack_nxt   = 1'b1;
               state_nxt = WAIT_REL;
            end
         end
         WAIT_REL: begin
            // An early req drop lands here with req_sync already low: ack lasts one cycle
            if (!req_sync) begin
               ack_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            ack_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

`ifdef DATA_SYNC_RSP_PARITY_EN
   logic capture;
   logic par_bad;

   assign capture = (state == IDLE) && req_sync;
   assign par_bad = (^src_data) != src_parity;

   // A mismatch on the capture edge wins over a simultaneous clear
   always_ff @(posedge dest_clk or negedge dest_rst) begin
      if (!dest_rst) begin
         parity_err <= 1'b0;
      end else if (capture && par_bad) begin
         parity_err <= 1'b1;
      end else if (err_clr) begin
         parity_err <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/data_sync_rsp.md
Name: data_sync_rsp

Overview:
- Destination-domain responder for a 4-phase req/ack clock-domain-crossing handshake.
- Synchronizes the source's level request and captures the source-held data bus.
- Presents the captured word to a local consumer with valid/ready, then returns a registered, glitch-free ack level to the source domain.
- Sits at the destination end of every multi-bit crossing where the source must know the word was consumed before launching the next one.

Parameters:
- BUS_WIDTH, 8, width of data bus.
- SYNC_STAGES, 2, flops in req synchronizer chain; legal range >= 2.

Ports:
- dest_clk  input  1  destination clock.
- dest_rst  input  1  reset, asynchronous, active-low.
- src_req  input  1  request level from source domain; asynchronous to dest_clk.
- src_data  input  BUS_WIDTH  source data; source holds it stable from req rise until it sees ack rise.
- dest_ready  input  1  consumer accepts dest_data this cycle.
- dest_data  output  BUS_WIDTH  captured word, registered.
- dest_valid  output  1  dest_data valid, registered.
- src_ack  output  1  ack level to source domain; driven directly from a dest_clk flop, no combinational logic after it.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (dest_rst low, async): all sync flops 0, state IDLE, dest_data 0, dest_valid 0, src_ack 0, busy 0.
- req_sync is the output of the last stage of the SYNC_STAGES chain sampling src_req. No other logic touches src_req.
- src_data is sampled only on the capture edge. At that point it has been stable for >= SYNC_STAGES cycles by protocol, so it needs no per-bit synchronizer.
- IDLE: when req_sync=1, dest_data <= src_data, dest_valid <= 1, next state WAIT_RDY.
- WAIT_RDY: hold dest_data and dest_valid. On the edge where dest_valid&dest_ready: dest_valid <= 0, src_ack <= 1, next state WAIT_REL.
- WAIT_REL: src_ack held 1. When req_sync=0: src_ack <= 0, next state IDLE.
- The 2-bit state encoding is local; busy decodes it combinationally (busy is not a crossing signal).
- Latency:
  - src_req rise, once captured by stage 1, reaches req_sync after SYNC_STAGES-1 further edges.
  - dest_valid rises on the next edge after req_sync rises.
  - With dest_ready held high, src_ack rises 1 cycle after dest_valid.
- Back-to-back words: a new capture needs the full cycle of req low seen, ack low, req high seen. Double-capture of one request is impossible because WAIT_REL exits only on req_sync=0.
- dest_ready high while dest_valid=0 has no effect.
- dest_ready may stay high permanently; each word is then valid for exactly 1 cycle.
- Protocol violation (src_req falls during WAIT_RDY): transaction still completes with the captured word. WAIT_REL then exits on the next edge, so src_ack is high for exactly 1 cycle.
- Reset mid-operation: everything returns to reset values immediately and any in-flight word is discarded. If src_req is still high after reset release, it is treated as a new request and re-captured. The source must tolerate a repeat.
- Outputs never change except on dest_clk posedge or reset assertion.

Optional Feature:
- Macro: DATA_SYNC_RSP_PARITY_EN.
- Defined:
  - Adds input src_parity (1), even parity over src_data, held like src_data.
  - Adds input err_clr (1), synchronous clear.
  - Adds output parity_err (1), sticky, reset 0.
  - On the IDLE capture edge, if (^src_data) != src_parity, parity_err <= 1. The word is still delivered normally.
  - err_clr=1 clears parity_err. A mismatch on the same edge as err_clr wins, so parity_err=1.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single transfer, SYNC_STAGES=2, dest_ready=1: src_data=0xA5, raise src_req.
  - dest_valid high for 1 cycle with dest_data=0xA5, exactly 2 edges after stage 1 samples req high.
  - src_ack rises next cycle.
  - Drop src_req: src_ack falls 2 cycles later; busy returns 0.
- Backpressure: dest_ready=0 for 10 cycles after valid.
  - dest_valid and dest_data=0x3C stable all 10 cycles; src_ack stays 0.
  - Assert ready: valid drops and ack rises on that edge.
- Back-to-back words 0x01, 0x02, 0x03 with full 4-phase handshake at an asynchronous src clock ratio of 3.7:1: consumer receives exactly three words in order, no duplicates.
- Early req drop in WAIT_RDY: word delivered once and src_ack high exactly 1 cycle.
- Reset asserted in WAIT_RDY with src_req held high:
  - Outputs are 0 immediately.
  - After release, the word is re-captured and dest_valid reasserts SYNC_STAGES+1 edges later.
- With DATA_SYNC_RSP_PARITY_EN:
  - src_data=0x07, src_parity=0: parity_err=1 and the word is still delivered.
  - Pulse err_clr: parity_err=0.
  - Correct parity 0x07/1 on a later word: parity_err stays 0.
